mul_hilo_ctrl: RTL

- EX-stage sequencer between decoded multiply instructions and the iterative shift-add multiplier (start/annul/ready/64-bit result handshake).
- Latches operands, holds the multiplier's start level until ready, and stalls the pipeline meanwhile.
- Post-processes the 64-bit product into HI/LO writes or a GPR write, including the MADD/MSUB accumulate forms.

---
 rtl/mul_hilo_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mul_hilo_ctrl.sv
// EX-stage sequencer for the iterative multiplier: issue, stall, timeout and HI/LO or GPR write-back.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MUL_ACC_EN.
module mul_hilo_ctrl #(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    output logic        mul_start_o,
    output logic        mul_annul_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        stall_req_o,
    output logic        done_o,
    output logic        err_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [31:0]        r_src1;
    logic [31:0]        r_src2;
    logic               r_whilo;
    logic               r_wreg;
    logic               r_err;
    logic [63:0]        r_res;
    logic               w_supported;
    logic               w_issue;
    logic               w_busy;
    logic               w_done;
    logic               w_timeout;
    logic               w_finish;
    logic [63:0]        w_hilo;

`ifdef MUL_ACC_EN
    logic [63:0]        r_acc;

    function automatic logic [63:0] f_hilo(input logic [2:0] op, input logic [63:0] p,
                                           input logic [63:0] acc);
        case (op)
            OP_MADD, OP_MADDU: f_hilo = acc + p;
            OP_MSUB, OP_MSUBU: f_hilo = acc - p;
            default:           f_hilo = p;
        endcase
    endfunction

    assign w_supported = (op_i != OP_NOP);
    assign w_hilo      = f_hilo(r_op, mul_result_i, r_acc);
`else
    logic               w_unused_acc;

    // Accumulate opcodes are rejected outright, so HI/LO forwarding is never consumed.
    assign w_supported  = (op_i != OP_NOP) && !op_i[2];
    assign w_hilo       = mul_result_i;
    assign w_unused_acc = ^{hi_i, lo_i};
`endif

    assign w_busy    = (r_state == S_BUSY);
    assign w_done    = (r_state == S_DONE);
    assign w_issue   = op_valid_i && w_supported && !flush_i;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_finish  = w_busy && !flush_i && (mul_ready_i || w_timeout);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_next = S_BUSY;
            S_BUSY: begin
                if (flush_i)
                    w_next = S_IDLE;
                else if (mul_ready_i || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst || !w_busy)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // Write-back flags are captured on the last BUSY cycle and presented during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_whilo <= 1'b0;
            r_wreg  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_finish) begin
            r_err   <= !mul_ready_i;
            r_whilo <= mul_ready_i && (r_op != OP_MUL);
            r_wreg  <= mul_ready_i && (r_op == OP_MUL);
        end
    end

    always_ff @(posedge clk) begin
        if (!w_busy && !w_done && w_issue) begin
            r_op   <= op_i;
            r_src1 <= src1_i;
            r_src2 <= src2_i;
`ifdef MUL_ACC_EN
            r_acc  <= {hi_i, lo_i};
`endif
        end
        if (w_finish)
            r_res <= (r_op == OP_MUL) ? {32'b0, mul_result_i[31:0]} : w_hilo;
    end

    always_comb begin
        mul_signed_o = 1'b0;
        if (w_busy) begin
            case (r_op)
                OP_MULT, OP_MUL, OP_MADD, OP_MSUB: mul_signed_o = 1'b1;
                default:                           mul_signed_o = 1'b0;
            endcase
        end
    end

    assign mul_start_o = w_busy;
    assign mul_annul_o = flush_i && w_busy;
    assign mul_op1_o   = w_busy ? r_src1 : 32'b0;
    assign mul_op2_o   = w_busy ? r_src2 : 32'b0;
    assign stall_req_o = w_busy || ((r_state == S_IDLE) && w_issue);
    assign done_o      = w_done;
    assign err_o       = w_done && r_err;
    assign whilo_o     = w_done && r_whilo && !flush_i;
    assign wreg_o      = w_done && r_wreg && !flush_i;
    assign hi_o        = (w_done && r_whilo) ? r_res[63:32] : 32'b0;
    assign lo_o        = (w_done && r_whilo) ? r_res[31:0] : 32'b0;
    assign wdata_o     = (w_done && r_wreg) ? r_res[31:0] : 32'b0;

endmodule
